// File: rtl/lb_fabric_pkg.sv
// Shared types and helpers for the local-bus fabric.
package lb_fabric_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lb_fabric_state_t;
  typedef enum logic [1:0] {RSP_OK, RSP_ERR, RSP_TMO} lb_fabric_rsp_t;

  // Block select is the top blk_w bits of an addr_w-wide address.
  function automatic int blk_of(input logic [63:0] addr, input int addr_w, input int blk_w);
    return 32'((addr >> (addr_w - blk_w)) & ((64'd1 << blk_w) - 64'd1));
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lb_fabric_if.sv
// Parent and child local-bus signals of the fabric; slave is the fabric side.
interface lb_fabric_if #(
  parameter int LB_DATA_W     = 32,
  parameter int LB_ADDR_W     = 16,
  parameter int LB_ADDR_BLK_W = 4,
  parameter int NUM_CHILDREN  = 3
);
  logic                                  lb_wr_en;
  logic                                  lb_rd_en;
  logic [LB_ADDR_W-1:0]                  lb_addr;
  logic [LB_DATA_W-1:0]                  lb_wr_data;
  logic                                  lb_wr_valid;
  logic                                  lb_rd_valid;
  logic [LB_DATA_W-1:0]                  lb_rd_data;
  logic [NUM_CHILDREN-1:0]               chld_lb_wr_en;
  logic [NUM_CHILDREN-1:0]               chld_lb_rd_en;
  logic [LB_ADDR_W-LB_ADDR_BLK_W-1:0]    chld_lb_addr;
  logic [LB_DATA_W-1:0]                  chld_lb_wr_data;
  logic [NUM_CHILDREN-1:0]               chld_lb_wr_valid;
  logic [NUM_CHILDREN-1:0]               chld_lb_rd_valid;
  logic [NUM_CHILDREN*LB_DATA_W-1:0]     chld_lb_rd_data;

  modport master (
    output lb_wr_en, lb_rd_en, lb_addr, lb_wr_data,
    input  lb_wr_valid, lb_rd_valid, lb_rd_data,
    input  chld_lb_wr_en, chld_lb_rd_en, chld_lb_addr, chld_lb_wr_data,
    output chld_lb_wr_valid, chld_lb_rd_valid, chld_lb_rd_data
  );

  modport slave (
    input  lb_wr_en, lb_rd_en, lb_addr, lb_wr_data,
    output lb_wr_valid, lb_rd_valid, lb_rd_data,
    output chld_lb_wr_en, chld_lb_rd_en, chld_lb_addr, chld_lb_wr_data,
    input  chld_lb_wr_valid, chld_lb_rd_valid, chld_lb_rd_data
  );
endinterface

// File: rtl/lb_fabric_tmr.sv
// Transaction timer: load in the child-strobe cycle, expired_o is high on the
// TIMEOUT_CYCLES-th cycle after it and stays high until cleared.
module lb_fabric_tmr #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic clr_i,
  output logic expired_o
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (clr_i) begin
      cnt_d = '0;
      run_d = 1'b0;
    end else if (load_i) begin
      cnt_d = TW'(TIMEOUT_CYCLES - 1);
      run_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign expired_o = run_q && (cnt_q == '0);
endmodule

// File: rtl/lb_fabric.sv
// Fans one parent local bus out to NUM_CHILDREN children with one transaction
// outstanding; unmapped or silent children get DEFAULT_DATA_VAL back.
module lb_fabric
  import lb_fabric_pkg::*;
#(
  parameter int                   LB_DATA_W        = 32,
  parameter int                   LB_ADDR_W        = 16,
  parameter int                   LB_ADDR_BLK_W    = 4,
  parameter int                   NUM_CHILDREN     = 3,
  parameter int                   TIMEOUT_CYCLES   = 64,
  parameter logic [LB_DATA_W-1:0] DEFAULT_DATA_VAL = 'hdeadbabe
) (
  input  logic        clk,
  input  logic        rst_n,
  lb_fabric_if.slave  bus,
  output logic [15:0] timeout_cnt,
  output logic [15:0] err_cnt,
  output logic        overrun
);
  localparam int CHLD_ADDR_W = LB_ADDR_W - LB_ADDR_BLK_W;

  lb_fabric_state_t         state_q, state_d;
  lb_fabric_rsp_t           rsp_q, rsp_d;
  logic                     op_wr_q, op_wr_d, mapped_q, mapped_d, hit_q, hit_d;
  logic [LB_ADDR_BLK_W-1:0] blk_q, blk_d, new_blk;
  logic [LB_DATA_W-1:0]     rdat_q, rdat_d, rd_data_q, rd_data_d, wdat_q, wdat_d, sel_dat;
  logic [CHLD_ADDR_W-1:0]   caddr_q, caddr_d;
  logic [NUM_CHILDREN-1:0]  cwr_q, cwr_d, crd_q, crd_d;
  logic                     wr_vld_q, wr_vld_d, rd_vld_q, rd_vld_d, ovr_q, ovr_d;
  logic [15:0]              tmo_q, tmo_d, err_q, err_d;
  logic                     req, sel_vld, tmr_load, tmr_clr, tmr_expired;
  int                       new_blk_int;

  assign req         = bus.lb_wr_en | bus.lb_rd_en;
  assign new_blk_int = blk_of(64'(bus.lb_addr), LB_ADDR_W, LB_ADDR_BLK_W);
  assign new_blk     = LB_ADDR_BLK_W'(new_blk_int);

  // Only the latched child and the latched op can complete the transaction.
  always_comb begin
    sel_vld = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      if (blk_q == LB_ADDR_BLK_W'(i)) begin
        sel_vld = op_wr_q ? bus.chld_lb_wr_valid[i] : bus.chld_lb_rd_valid[i];
        sel_dat = bus.chld_lb_rd_data[i*LB_DATA_W +: LB_DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rsp_d     = rsp_q;
    op_wr_d   = op_wr_q;
    mapped_d  = mapped_q;
    hit_d     = hit_q;
    blk_d     = blk_q;
    rdat_d    = rdat_q;
    wdat_d    = wdat_q;
    caddr_d   = caddr_q;
    rd_data_d = rd_data_q;
    cwr_d     = '0;
    crd_d     = '0;
    wr_vld_d  = 1'b0;
    rd_vld_d  = 1'b0;
    tmo_d     = tmo_q;
    err_d     = err_q;
    tmr_load  = 1'b0;
    tmr_clr   = 1'b0;
    ovr_d     = ovr_q | (req && state_q != IDLE) | (bus.lb_wr_en & bus.lb_rd_en);
    unique case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (req) begin
          op_wr_d  = bus.lb_wr_en;
          blk_d    = new_blk;
          mapped_d = new_blk_int < NUM_CHILDREN;
          caddr_d  = bus.lb_addr[CHLD_ADDR_W-1:0];
          wdat_d   = bus.lb_wr_data;
          hit_d    = 1'b0;
          state_d  = REQ;
          if (new_blk_int < NUM_CHILDREN) begin
            if (bus.lb_wr_en) cwr_d = NUM_CHILDREN'(1) << new_blk;
            else              crd_d = NUM_CHILDREN'(1) << new_blk;
          end
        end
      end
      REQ: begin
        if (!mapped_q) begin
          err_d   = sat_inc(err_q);
          rsp_d   = RSP_ERR;
          state_d = RESP;
        end else begin
          tmr_load = 1'b1;
          state_d  = WAIT;
          if (sel_vld) begin
            hit_d  = 1'b1;
            rdat_d = sel_dat;
          end
        end
      end
      WAIT: begin
        // A valid on the expiry cycle is captured here and beats the timeout.
        if (hit_q) begin
          rsp_d   = RSP_OK;
          state_d = RESP;
        end else if (sel_vld) begin
          hit_d  = 1'b1;
          rdat_d = sel_dat;
        end else if (tmr_expired) begin
          tmo_d   = sat_inc(tmo_q);
          rsp_d   = RSP_TMO;
          state_d = RESP;
        end
      end
      RESP: begin
        tmr_clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == RESP && state_q != RESP) begin
      wr_vld_d = op_wr_q;
      rd_vld_d = !op_wr_q;
      if (!op_wr_q) rd_data_d = (rsp_d == RSP_OK) ? rdat_q : DEFAULT_DATA_VAL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rsp_q     <= RSP_OK;
      op_wr_q   <= 1'b0;
      mapped_q  <= 1'b0;
      hit_q     <= 1'b0;
      blk_q     <= '0;
      rdat_q    <= '0;
      wdat_q    <= '0;
      caddr_q   <= '0;
      rd_data_q <= '0;
      cwr_q     <= '0;
      crd_q     <= '0;
      wr_vld_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      tmo_q     <= '0;
      err_q     <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_q     <= rsp_d;
      op_wr_q   <= op_wr_d;
      mapped_q  <= mapped_d;
      hit_q     <= hit_d;
      blk_q     <= blk_d;
      rdat_q    <= rdat_d;
      wdat_q    <= wdat_d;
      caddr_q   <= caddr_d;
      rd_data_q <= rd_data_d;
      cwr_q     <= cwr_d;
      crd_q     <= crd_d;
      wr_vld_q  <= wr_vld_d;
      rd_vld_q  <= rd_vld_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
    end
  end

  lb_fabric_tmr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .clr_i     (tmr_clr),
    .expired_o (tmr_expired)
  );

  assign bus.lb_wr_valid     = wr_vld_q;
  assign bus.lb_rd_valid     = rd_vld_q;
  assign bus.lb_rd_data      = rd_data_q;
  assign bus.chld_lb_wr_en   = cwr_q;
  assign bus.chld_lb_rd_en   = crd_q;
  assign bus.chld_lb_addr    = caddr_q;
  assign bus.chld_lb_wr_data = wdat_q;
  assign timeout_cnt         = tmo_q;
  assign err_cnt             = err_q;
  assign overrun             = ovr_q;
endmodule
